// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic-unit command sequencer.
// Holds the function codes understood by the arithmetic unit, the sequencer
// state encoding and a small helper used by the command decoder.
package alu_pkg;

  localparam logic [1:0] FUNC_ADD = 2'b00;
  localparam logic [1:0] FUNC_SUB = 2'b01;
  localparam logic [1:0] FUNC_MUL = 2'b10;
  localparam logic [1:0] FUNC_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  // A divide with a zero divisor is answered locally and never reaches the unit.
  function automatic logic is_div_by_zero(input logic [1:0] func, input logic b_is_zero);
    return (func == FUNC_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// Purpose : bounded wait counter; expire_o flags the last allowed WAIT cycle.
// Latency : clear/increment take effect on the next clock; expire_o is decoded from the count.
// Backpressure: none; counting pauses when en_i is low and holds once expired.
// Ports   : clk, rst (async active-low), clr_i (restart at 0), en_i (count this cycle),
//           expire_o (count has reached TIMEOUT-1).
module alu_seq_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Purpose : issues one command at a time to the arithmetic unit and returns its result.
// Latency : accept N, Arith_Enable N+1, flag expected N+2, rsp_valid N+3 (div-by-zero: rsp_valid N+1).
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready.
// Ports   : cmd_* command slave port; A/B/Arith_ALU_FUNC/Arith_Enable drive the unit;
//           Arith_OUT/Carry_OUT/Arith_Flag return from it; rsp_* response master port;
//           op_count counts successful operations (wraps).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [A_WIDTH-1:0]         cmd_a,
  input  logic [B_WIDTH-1:0]         cmd_b,
  input  logic [1:0]                 cmd_func,
  output logic [A_WIDTH-1:0]         A,
  output logic [B_WIDTH-1:0]         B,
  output logic [1:0]                 Arith_ALU_FUNC,
  output logic                       Arith_Enable,
  input  logic [A_WIDTH+B_WIDTH-1:0] Arith_OUT,
  input  logic                       Carry_OUT,
  input  logic                       Arith_Flag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] rsp_result,
  output logic                       rsp_carry,
  output logic                       rsp_err,
  output logic [CNT_WIDTH-1:0]       op_count
);

  localparam int RW = A_WIDTH + B_WIDTH;

  state_t               state_q;
  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  logic [1:0]           func_q;
  logic                 enable_q;
  logic                 rsp_valid_q;
  logic [RW-1:0]        rsp_result_q;
  logic                 rsp_carry_q;
  logic                 rsp_err_q;
  logic [CNT_WIDTH-1:0] op_count_q;

  logic to_clr;
  logic to_en;
  logic to_expire;

  // The wait budget restarts while the operation is being issued and only
  // advances on WAIT cycles that did not see the flag.
  assign to_clr = (state_q == ISSUE);
  assign to_en  = (state_q == WAIT) && !Arith_Flag;

  alu_seq_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .expire_o (to_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      func_q       <= FUNC_ADD;
      enable_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            a_q    <= cmd_a;
            b_q    <= cmd_b;
            func_q <= cmd_func;
            if (is_div_by_zero(cmd_func, cmd_b == '0)) begin
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              rsp_carry_q  <= 1'b0;
              state_q      <= RESP;
            end else begin
              // Registered strobe: high for the single cycle spent in ISSUE.
              enable_q <= 1'b1;
              state_q  <= ISSUE;
            end
          end
        end

        ISSUE: begin
          enable_q <= 1'b0;
          state_q  <= WAIT;
        end

        WAIT: begin
          // Flag is checked first so a flag on the expiry cycle still succeeds.
          if (Arith_Flag) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= Arith_OUT;
            rsp_carry_q  <= (func_q == FUNC_ADD) ? Carry_OUT : 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= op_count_q + CNT_WIDTH'(1);
            state_q      <= RESP;
          end else if (to_expire) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b1;
            state_q      <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign A              = a_q;
  assign B              = b_q;
  assign Arith_ALU_FUNC = func_q;
  assign Arith_Enable   = enable_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_carry      = rsp_carry_q;
  assign rsp_err        = rsp_err_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a one-cycle arithmetic unit model (optionally mute),
// a response scoreboard fed at command acceptance, and directed timing scenarios.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int AW = 16;
  localparam int BW = 16;
  localparam int RW = AW + BW;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_a;
  logic [BW-1:0] cmd_b;
  logic [1:0]    cmd_func;
  logic [AW-1:0] A;
  logic [BW-1:0] B;
  logic [1:0]    Arith_ALU_FUNC;
  logic          Arith_Enable;
  logic [RW-1:0] Arith_OUT;
  logic          Carry_OUT;
  logic          Arith_Flag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_result;
  logic          rsp_carry;
  logic          rsp_err;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .A_WIDTH   (AW),
    .B_WIDTH   (BW),
    .TIMEOUT   (15),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_func       (cmd_func),
    .A              (A),
    .B              (B),
    .Arith_ALU_FUNC (Arith_ALU_FUNC),
    .Arith_Enable   (Arith_Enable),
    .Arith_OUT      (Arith_OUT),
    .Carry_OUT      (Carry_OUT),
    .Arith_Flag     (Arith_Flag),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_carry      (rsp_carry),
    .rsp_err        (rsp_err),
    .op_count       (op_count)
  );

  int total  = 0;
  int passed = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Arithmetic result as the unit computes it, full output width.
  function automatic logic [RW-1:0] calc(logic [AW-1:0] a, logic [BW-1:0] b, logic [1:0] f);
    logic [RW-1:0] wa, wb;
    wa = RW'(a);
    wb = RW'(b);
    case (f)
      FUNC_ADD: calc = wa + wb;
      FUNC_SUB: calc = wa - wb;
      FUNC_MUL: calc = wa * wb;
      default:  calc = (b == '0) ? '0 : (wa / wb);
    endcase
  endfunction

  // One-cycle unit. On non-add ops it reports carry=1 so masking is visible.
  logic          stub       = 1'b0;
  logic          stray_flag = 1'b0;
  logic          unit_flag  = 1'b0;
  logic [RW-1:0] unit_out   = '0;
  logic          unit_carry = 1'b0;

  always @(posedge clk) begin
    unit_flag <= Arith_Enable && !stub;
    if (Arith_Enable) begin
      unit_out   <= calc(A, B, Arith_ALU_FUNC);
      unit_carry <= (Arith_ALU_FUNC == FUNC_ADD) ? calc(A, B, Arith_ALU_FUNC)[AW] : 1'b1;
    end
  end

  assign Arith_OUT  = unit_out;
  assign Carry_OUT  = unit_carry;
  assign Arith_Flag = unit_flag | stray_flag;

  typedef struct {
    logic [RW-1:0] res;
    logic          carry;
    logic          err;
  } exp_t;

  exp_t q[$];
  logic [CW-1:0] model_cnt = '0;
  int en_seen = 0;

  always @(negedge clk) if (Arith_Enable) en_seen++;

  // Scoreboard: every cycle a response is presented it must match the oldest
  // expectation; a successful op is already counted while the response waits.
  always @(negedge clk) begin : cmp
    logic [CW-1:0] ec;
    if (!rst) begin
      q.delete();
      model_cnt = '0;
    end else if (rsp_valid) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        ec = model_cnt + (q[0].err ? CW'(0) : CW'(1));
        check("sb_result", rsp_result, q[0].res);
        check("sb_carry", rsp_carry, q[0].carry);
        check("sb_err", rsp_err, q[0].err);
        check("sb_op_count", op_count, ec);
        if (rsp_ready) begin
          model_cnt = ec;
          void'(q.pop_front());
        end
      end
    end
  end

  // Present a command until accepted; the expectation is queued at acceptance.
  task automatic issue(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [1:0] f);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_func  = f;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_accepted", ok, 1);
    if (ok) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (ok) begin
      if ((f == FUNC_DIV && b == '0) || stub) begin
        e.res = '0; e.carry = 1'b0; e.err = 1'b1;
      end else begin
        e.res   = calc(a, b, f);
        e.carry = (f == FUNC_ADD) ? e.res[AW] : 1'b0;
        e.err   = 1'b0;
      end
      q.push_back(e);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  initial begin : stim
    int  b0;
    bit  early;
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_func = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_func", Arith_ALU_FUNC, 0);
    check("rst_enable", Arith_Enable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_op_count", op_count, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Add with carry out, standard latency.
    b0 = en_seen;
    issue(16'hFFFF, 16'h0001, FUNC_ADD);
    @(negedge clk); check("t1_enable_n1", Arith_Enable, 1);
    @(negedge clk); check("t1_enable_n2", Arith_Enable, 0); check("t1_valid_n2", rsp_valid, 0);
    @(negedge clk);
    check("t1_valid_n3", rsp_valid, 1);
    check("t1_result", rsp_result, 32'h0001_0000);
    check("t1_carry", rsp_carry, 1);
    check("t1_err", rsp_err, 0);
    check("t1_op_count", op_count, 1);
    check("t1_one_pulse", en_seen - b0, 1);

    // Subtract underflow; carry masked.
    issue(16'h0005, 16'h0007, FUNC_SUB);
    repeat (3) @(negedge clk);
    check("t2_valid", rsp_valid, 1);
    check("t2_result", rsp_result, 32'hFFFF_FFFE);
    check("t2_carry", rsp_carry, 0);
    check("t2_op_count", op_count, 2);

    // Divide by zero answered locally.
    b0 = en_seen;
    issue(16'h0064, 16'h0000, FUNC_DIV);
    @(negedge clk);
    check("t3_valid_n1", rsp_valid, 1);
    check("t3_err", rsp_err, 1);
    check("t3_result", rsp_result, 0);
    check("t3_op_count", op_count, 2);
    repeat (2) @(negedge clk);
    check("t3_no_enable", en_seen - b0, 0);

    issue(16'd100, 16'd7, FUNC_DIV);
    repeat (3) @(negedge clk);
    check("t3b_result", rsp_result, 32'd14);
    check("t3b_op_count", op_count, 3);

    // Multiply with the response stalled; a new command waits behind it.
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(16'h0100, 16'h0100, FUNC_MUL);
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 16'd1; cmd_b = 16'd2; cmd_func = FUNC_ADD;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_result", rsp_result, 32'h0001_0000);
      check("t4_cmd_blocked", cmd_ready, 0);
      check("t4_A_unchanged", A, 16'h0100);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    issue(16'd1, 16'd2, FUNC_ADD);
    @(negedge clk);
    check("t4_next_enable", Arith_Enable, 1);
    check("t4_next_A", A, 16'd1);
    repeat (2) @(negedge clk);
    check("t4_next_result", rsp_result, 32'd3);
    check("t4_next_op_count", op_count, 5);

    // Unit never answers: timeout after 15 WAIT cycles.
    @(posedge clk); #1 stub = 1'b1;
    issue(16'd3, 16'd4, FUNC_ADD);
    @(negedge clk); check("t5_enable", Arith_Enable, 1);
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) early = 1'b1;
    end
    check("t5_not_early", early, 0);
    @(negedge clk);
    check("t5_valid", rsp_valid, 1);
    check("t5_err", rsp_err, 1);
    check("t5_result", rsp_result, 0);
    check("t5_op_count", op_count, 5);
    @(negedge clk);
    check("t5_idle", cmd_ready, 1);

    // Reset while waiting, then a stray flag in IDLE.
    issue(16'd9, 16'd9, FUNC_ADD);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_A", A, 0);
    check("t6_B", B, 0);
    check("t6_enable", Arith_Enable, 0);
    check("t6_valid", rsp_valid, 0);
    check("t6_err", rsp_err, 0);
    check("t6_op_count", op_count, 0);
    @(posedge clk); #1;
    rst = 1'b1; stray_flag = 1'b1; stub = 1'b0;
    @(negedge clk);
    check("t6_stray_valid", rsp_valid, 0);
    check("t6_stray_ready", cmd_ready, 1);
    @(posedge clk); #1 stray_flag = 1'b0;
    @(negedge clk);
    check("t6_stray_valid2", rsp_valid, 0);

    // 256 successful ops wrap the counter.
    for (int i = 0; i < 256; i++) issue(16'(i), 16'd1, FUNC_ADD);
    repeat (3) @(negedge clk);
    check("t7_valid", rsp_valid, 1);
    check("t7_wrap", op_count, 0);
    @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
